// File: rtl/page_reader_if.sv
// page_reader_if: output word stream of page_reader (data, page tag, last-of-page flag).
// Ports: data_o/page_o/last_o/valid_o flow from the reader (master) to the consumer (slave);
//        ready_i flows back from the consumer. A word transfers when valid_o && ready_i.
interface page_reader_if #(
  parameter int RAM_WIDTH = 18,
  parameter int PAGE_W    = 3
);
  logic [RAM_WIDTH-1:0] data_o;
  logic [PAGE_W-1:0]    page_o;
  logic                 last_o;
  logic                 valid_o;
  logic                 ready_i;

  modport master (
    output data_o,
    output page_o,
    output last_o,
    output valid_o,
    input  ready_i
  );

  modport slave (
    input  data_o,
    input  page_o,
    input  last_o,
    input  valid_o,
    output ready_i
  );
endinterface

// File: rtl/page_reader.sv
// page_reader_fifo: show-ahead FIFO, head word visible whenever pop_vld_o is high.
// Latency: a pushed word is visible the cycle after the push.
// Backpressure: head holds while pop_rdy_i is low; pushes beyond DEPTH are dropped (callers reserve space).
// Ports: push_vld_i/push_dat_i write side, pop_vld_o/pop_rdy_i/pop_dat_o read side, count_o fill level.
module page_reader_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld_i,
  input  logic [W-1:0]     push_dat_i,
  output logic             pop_vld_o,
  input  logic             pop_rdy_i,
  output logic [W-1:0]     pop_dat_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop       = (cnt_q != '0) && pop_rdy_i;
  assign push      = push_vld_i && ((cnt_q != CNT_W'(DEPTH)) || pop);
  assign pop_vld_o = (cnt_q != '0);
  assign pop_dat_o = mem_q[rd_ptr_q];
  assign count_o   = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)      cnt_q <= cnt_q + CNT_W'(1);
      else if (pop && !push) cnt_q <= cnt_q - CNT_W'(1);
    end
  end
endmodule

// page_reader: walks pages 0..PAGES-1 of a paged BRAM, reading nent[p] words per page into a tagged stream.
// Latency: first word on the stream RD_LAT+1 cycles after the first read is issued; 1 word/cycle sustained.
// Backpressure: reads issue only while FIFO fill + reads in flight < FIFO_DEPTH, so ready_i low stalls the walk.
// Ports: clk/rst (sync active-high); start pulse; nent_i packed per-page counts;
//        addrb/enb/regceb/doutb to the memory read port; st stream (data/page/last, valid/ready);
//        busy while a scan runs; done one-cycle pulse once the last word has been accepted.
module page_reader #(
  parameter int RAM_WIDTH   = 18,
  parameter int ADDR_W      = 10,
  parameter int PAGES       = 8,
  parameter int NENT_W      = 5,
  parameter int PAGE_STRIDE = 32,
  parameter int RD_LAT      = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int PAGE_W      = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [PAGES*NENT_W-1:0]  nent_i,
  output logic [ADDR_W-1:0]        addrb,
  output logic                     enb,
  output logic                     regceb,
  input  logic [RAM_WIDTH-1:0]     doutb,
  output logic                     busy,
  output logic                     done,
  page_reader_if.master            st
);
  localparam int PCNT_W = $clog2(PAGES + 1);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int LAT_W  = $clog2(RD_LAT + 1);
  localparam int FW     = RAM_WIDTH + PAGE_W + 1;

  typedef enum logic [1:0] {IDLE, SCAN, READ, DRAIN} state_t;

  typedef struct packed {
    logic              vld;
    logic [PAGE_W-1:0] page;
    logic              last;
  } tag_t;

  state_t                    state_q, state_d;
  logic [PCNT_W-1:0]         page_q, page_d;   // reaches PAGES to mark the end of the walk
  logic [NENT_W-1:0]         idx_q, idx_d;
  logic [PAGES*NENT_W-1:0]   nent_q;
  logic                      latch;
  logic                      issue;
  logic                      room;
  logic [NENT_W-1:0]         nent_arr [PAGES];
  logic [NENT_W-1:0]         cur_nent;
  logic                      is_last;
  tag_t                      tag_q [RD_LAT];
  tag_t                      tag_new;
  logic [LAT_W-1:0]          inflight;
  logic [CNT_W-1:0]          fifo_cnt;
  logic [FW-1:0]             fifo_dat;

  always_comb begin
    for (int p = 0; p < PAGES; p++) nent_arr[p] = nent_q[p*NENT_W +: NENT_W];
  end

  assign cur_nent = nent_arr[page_q[PAGE_W-1:0]];
  assign is_last  = (idx_q == cur_nent - NENT_W'(1));

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + LAT_W'(tag_q[i].vld);
  end

  // Counting in-flight reads as already occupying the FIFO guarantees every
  // returning word has a slot, whatever ready_i does meanwhile.
  assign room = (int'(fifo_cnt) + int'(inflight)) < FIFO_DEPTH;

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    latch   = 1'b0;
    issue   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          page_d  = '0;
          idx_d   = '0;
          latch   = 1'b1;
        end
      end
      SCAN: begin
        if (page_q == PCNT_W'(PAGES)) begin
          state_d = DRAIN;
        end else if (cur_nent == '0) begin
          page_d = page_q + PCNT_W'(1);
        end else begin
          state_d = READ;
          idx_d   = '0;
        end
      end
      READ: begin
        if (room) begin
          issue = 1'b1;
          if (is_last) begin
            page_d  = page_q + PCNT_W'(1);
            idx_d   = '0;
            state_d = SCAN;
          end else begin
            idx_d = idx_q + NENT_W'(1);
          end
        end
      end
      DRAIN: begin
        if (inflight == '0 && fifo_cnt == '0) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tag_new      = '0;
    tag_new.vld  = issue;
    tag_new.page = issue ? page_q[PAGE_W-1:0] : '0;
    tag_new.last = issue && is_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      page_q  <= '0;
      idx_q   <= '0;
      nent_q  <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      idx_q    <= idx_d;
      if (latch) nent_q <= nent_i;
      tag_q[0] <= tag_new;
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // The memory pipeline has no valid of its own; keeping both enables high
  // while any tag is in flight keeps doutb in step with the tag shift register.
  assign enb    = issue || (inflight != '0);
  assign regceb = enb;
  assign addrb  = ADDR_W'(page_q) * ADDR_W'(PAGE_STRIDE) + ADDR_W'(idx_q);
  assign busy   = (state_q != IDLE);

  page_reader_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_vld_i (tag_q[RD_LAT-1].vld),
    .push_dat_i ({tag_q[RD_LAT-1].last, tag_q[RD_LAT-1].page, doutb}),
    .pop_vld_o  (st.valid_o),
    .pop_rdy_i  (st.ready_i),
    .pop_dat_o  (fifo_dat),
    .count_o    (fifo_cnt)
  );

  assign {st.last_o, st.page_o, st.data_o} = fifo_dat;
endmodule

// File: tb/tb_page_reader.sv
// tb_page_reader: directed bench for page_reader with a 2-cycle BRAM model returning word = address.
// Ports: drives clk/rst/start/nent_i/doutb and the stream ready; observes addrb/enb/regceb, stream, busy/done.
module tb_page_reader;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [39:0] nent_i;
  logic [9:0]  addrb;
  logic        enb;
  logic        regceb;
  logic [17:0] doutb;
  logic [17:0] mem_r1;
  logic        busy;
  logic        done;

  page_reader_if #(.RAM_WIDTH(18), .PAGE_W(3)) st ();

  page_reader dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .nent_i (nent_i),
    .addrb  (addrb),
    .enb    (enb),
    .regceb (regceb),
    .doutb  (doutb),
    .busy   (busy),
    .done   (done),
    .st     (st)
  );

  always #5 clk = ~clk;

  // Two-stage read port: array read on enb, output register on regceb.
  always @(posedge clk) begin
    if (enb)    mem_r1 <= {8'b0, addrb};
    if (regceb) doutb  <= mem_r1;
  end

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int issue_cnt = 0;
  int enb_cnt = 0;
  int max_fill = 0;
  int rx_dat[$];
  int rx_pg[$];
  int rx_last[$];

  int ea_d[4] = '{0, 1, 2, 224};
  int ea_p[4] = '{0, 0, 0, 7};
  int ea_l[4] = '{0, 0, 1, 1};
  int ee_d[3] = '{0, 1, 160};
  int ee_p[3] = '{0, 0, 5};
  int ee_l[3] = '{0, 1, 1};

  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (dut.issue) issue_cnt++;
      if (enb) enb_cnt++;
      if (int'(dut.fifo_cnt) > max_fill) max_fill = int'(dut.fifo_cnt);
      if (st.valid_o && st.ready_i) begin
        rx_dat.push_back(int'(st.data_o));
        rx_pg.push_back(int'(st.page_o));
        rx_last.push_back(int'(st.last_o));
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_nent(input int p, input int v);
    nent_i[p*5 +: 5] = 5'(v);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_rx();
    rx_dat.delete();
    rx_pg.delete();
    rx_last.delete();
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, done_cnt - d0, 1);
  endtask

  function automatic int rx_word(input int i);
    return (i < rx_dat.size()) ? rx_dat[i] : -1;
  endfunction

  // Words base..base+n-1 on page pg, last only on the final one.
  function automatic int count_bad(input int base, input int n, input int pg);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (i >= rx_dat.size()) bad++;
      else if (rx_dat[i] != base + i || rx_pg[i] != pg || rx_last[i] != int'(i == n - 1)) bad++;
    end
    return bad;
  endfunction

  initial begin
    logic [15:0] pat;
    int          n;
    int          d0;
    int          e0;
    int          i0;

    rst = 1'b1;
    start = 1'b0;
    nent_i = '0;
    st.ready_i = 1'b1;
    pat = 16'b1001_0110_0011_1010;
    tick(2);

    // Reset state
    check("rst_addrb", addrb, 0);
    check("rst_enb", enb, 0);
    check("rst_regceb", regceb, 0);
    check("rst_valid", st.valid_o, 0);
    check("rst_data", st.data_o, 0);
    check("rst_page", st.page_o, 0);
    check("rst_last", st.last_o, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    tick();

    // Pages 0 and 7 populated, ready held high
    clear_rx();
    set_nent(0, 3);
    set_nent(7, 1);
    i0 = issue_cnt;
    pulse_start();
    check("A_busy_after_start", busy, 1);
    tick(3);
    check("A_valid_before_latency", st.valid_o, 0);
    tick();
    check("A_valid_at_latency", st.valid_o, 1);
    check("A_first_data", st.data_o, 0);
    wait_done("A_done", 60);
    check("A_count", rx_dat.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("A_dat%0d", i), rx_word(i), ea_d[i]);
      check($sformatf("A_pg%0d", i), (i < rx_pg.size()) ? rx_pg[i] : -1, ea_p[i]);
      check($sformatf("A_last%0d", i), (i < rx_last.size()) ? rx_last[i] : -1, ea_l[i]);
    end
    check("A_issued_reads", issue_cnt - i0, 4);
    check("A_busy_low", busy, 0);

    // All pages empty: done exactly PAGES+2 cycles after start
    clear_rx();
    nent_i = '0;
    e0 = enb_cnt;
    d0 = done_cnt;
    pulse_start();
    tick(8);
    check("B_done_early", done, 0);
    tick();
    check("B_done_at_10", done, 1);
    tick();
    check("B_done_one_cycle", done, 0);
    check("B_busy_low", busy, 0);
    check("B_done_count", done_cnt - d0, 1);
    check("B_no_enb", enb_cnt - e0, 0);
    check("B_no_words", rx_dat.size(), 0);

    // Full page 2 (31 entries) under a stuttering ready
    clear_rx();
    nent_i = '0;
    set_nent(2, 31);
    max_fill = 0;
    pulse_start();
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < 400) begin
      st.ready_i = pat[n % 16];
      tick();
      n++;
    end
    st.ready_i = 1'b1;
    check("C_done", done_cnt - d0, 1);
    check("C_count", rx_dat.size(), 31);
    check("C_sequence_bad", count_bad(64, 31, 2), 0);
    check("C_fill_le_4", int'(max_fill <= 4), 1);

    // Consumer stalled: four words buffered, reads stop with address held
    clear_rx();
    nent_i = '0;
    set_nent(0, 8);
    st.ready_i = 1'b0;
    pulse_start();
    tick(19);
    check("F_fifo_full", dut.fifo_cnt, 4);
    check("F_enb_stopped", enb, 0);
    check("F_addrb_held", addrb, 4);
    check("F_valid", st.valid_o, 1);
    check("F_head_data", st.data_o, 0);
    tick(3);
    check("F_addrb_still_held", addrb, 4);
    check("F_head_stable", st.data_o, 0);
    check("F_none_taken", rx_dat.size(), 0);
    st.ready_i = 1'b1;
    wait_done("F_done", 60);
    check("F_count", rx_dat.size(), 8);
    check("F_sequence_bad", count_bad(0, 8, 0), 0);

    // Start while busy with new counts is ignored
    clear_rx();
    nent_i = '0;
    set_nent(0, 2);
    set_nent(5, 1);
    pulse_start();
    tick(2);
    nent_i = '0;
    set_nent(3, 4);
    pulse_start();
    wait_done("E_done", 60);
    check("E_count", rx_dat.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("E_dat%0d", i), rx_word(i), ee_d[i]);
      check($sformatf("E_pg%0d", i), (i < rx_pg.size()) ? rx_pg[i] : -1, ee_p[i]);
      check($sformatf("E_last%0d", i), (i < rx_last.size()) ? rx_last[i] : -1, ee_l[i]);
    end
    d0 = done_cnt;
    tick(15);
    check("E_no_second_scan", done_cnt - d0, 0);
    check("E_no_extra_words", rx_dat.size(), 3);

    // Reset in the middle of a READ burst
    clear_rx();
    nent_i = '0;
    set_nent(0, 8);
    pulse_start();
    tick(3);
    rst = 1'b1;
    tick();
    check("D_valid", st.valid_o, 0);
    check("D_enb", enb, 0);
    check("D_regceb", regceb, 0);
    check("D_busy", busy, 0);
    check("D_addrb", addrb, 0);
    check("D_data", st.data_o, 0);
    check("D_done", done, 0);
    rst = 1'b0;
    d0 = done_cnt;
    tick(20);
    check("D_no_done", done_cnt - d0, 0);
    check("D_no_words", rx_dat.size(), 0);
    clear_rx();
    nent_i = '0;
    set_nent(1, 2);
    pulse_start();
    wait_done("D_rescan_done", 60);
    check("D_rescan_count", rx_dat.size(), 2);
    check("D_rescan_bad", count_bad(32, 2, 1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
